// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle for rr_mux_arbiter: N valid/ready/data input lanes and one
// registered output channel tagged with the source index.
interface rr_mux_arbiter_if #(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int SW = $clog2(N);

   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_src;
   logic           out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_src
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter with a one-entry registered output stage; grants
// rotate from the slot after the last winner so no requester starves.
module rr_mux_arbiter #(
   parameter int N = 4,
   parameter int W = 8
) (
   input logic           clk,
   input logic           rst,
   rr_mux_arbiter_if.slave bus
);
   localparam int SW = $clog2(N);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] ptr, ptr_nxt;
   logic [SW-1:0] win;
   logic [W-1:0]  win_data;
   logic          found;
   logic          can_load;
   logic          load;
   logic [W-1:0]  data_q;
   logic [SW-1:0] src_q;

   // Search ptr, ptr+1, ... modulo N so non-power-of-two N never aliases.
   always_comb begin
      int unsigned idx;
      idx      = 0;
      found    = 1'b0;
      win      = '0;
      win_data = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && bus.in_valid[idx]) begin
            found    = 1'b1;
            win      = SW'(idx);
            win_data = bus.in_data[idx*W +: W];
         end
      end
   end

   assign can_load = (state == EMPTY) || bus.out_ready;
   assign load     = found && can_load && !rst;

   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      if (load) begin
         state_nxt = FULL;
         ptr_nxt   = (win == SW'(N - 1)) ? '0 : win + SW'(1);
      end else if (state == FULL && bus.out_ready) begin
         state_nxt = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr    <= '0;
         data_q <= '0;
         src_q  <= '0;
      end else begin
         ptr <= ptr_nxt;
         if (load) begin
            data_q <= win_data;
            src_q  <= win;
         end
      end
   end

   assign bus.in_ready  = load ? (N'(1) << win) : '0;
   assign bus.out_valid = (state == FULL);
   assign bus.out_data  = data_q;
   assign bus.out_src   = src_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: vector table on an N=4 instance plus a
// hand-written rotation sequence on an N=3 instance.
module tb_rr_mux_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic rst3;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter_if #(.N(4), .W(8)) u4 ();
   rr_mux_arbiter_if #(.N(3), .W(8)) u3 ();

   rr_mux_arbiter #(.N(4), .W(8)) dut4 (.clk(clk), .rst(rst),  .bus(u4));
   rr_mux_arbiter #(.N(3), .W(8)) dut3 (.clk(clk), .rst(rst3), .bus(u3));

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] data;
      logic        oready;
      logic [3:0]  exp_ready;
      logic        exp_ovalid;
      logic [7:0]  exp_odata;
      logic [1:0]  exp_osrc;
   } vec_t;

   localparam logic [31:0] D  = 32'h33221100;
   localparam logic [31:0] DA = 32'h3322A500;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      vec_t vecs[28];
      vecs = '{
         // rst, valid, data, oready, exp_ready, ovalid, odata, osrc
         '{1'b1, 4'b1111, D,  1'b1, 4'b0000, 1'b0, 8'h00, 2'd0},
         '{1'b1, 4'b1111, D,  1'b1, 4'b0000, 1'b0, 8'h00, 2'd0},
         '{1'b0, 4'b1111, D,  1'b1, 4'b0001, 1'b1, 8'h00, 2'd0},
         '{1'b0, 4'b1111, D,  1'b1, 4'b0010, 1'b1, 8'h11, 2'd1},
         '{1'b0, 4'b1111, D,  1'b1, 4'b0100, 1'b1, 8'h22, 2'd2},
         '{1'b0, 4'b1111, D,  1'b1, 4'b1000, 1'b1, 8'h33, 2'd3},
         '{1'b0, 4'b1111, D,  1'b1, 4'b0001, 1'b1, 8'h00, 2'd0},
         '{1'b0, 4'b1111, D,  1'b1, 4'b0010, 1'b1, 8'h11, 2'd1},
         '{1'b0, 4'b1111, D,  1'b1, 4'b0100, 1'b1, 8'h22, 2'd2},
         '{1'b0, 4'b1111, D,  1'b1, 4'b1000, 1'b1, 8'h33, 2'd3},
         '{1'b0, 4'b0100, D,  1'b1, 4'b0100, 1'b1, 8'h22, 2'd2},
         '{1'b0, 4'b0101, D,  1'b1, 4'b0001, 1'b1, 8'h00, 2'd0},
         '{1'b0, 4'b0101, D,  1'b1, 4'b0100, 1'b1, 8'h22, 2'd2},
         '{1'b0, 4'b0101, D,  1'b1, 4'b0001, 1'b1, 8'h00, 2'd0},
         '{1'b0, 4'b0100, D,  1'b1, 4'b0100, 1'b1, 8'h22, 2'd2},
         '{1'b0, 4'b0101, D,  1'b0, 4'b0000, 1'b1, 8'h22, 2'd2},
         '{1'b0, 4'b0101, D,  1'b0, 4'b0000, 1'b1, 8'h22, 2'd2},
         '{1'b0, 4'b0101, D,  1'b0, 4'b0000, 1'b1, 8'h22, 2'd2},
         '{1'b0, 4'b0101, D,  1'b0, 4'b0000, 1'b1, 8'h22, 2'd2},
         '{1'b0, 4'b0101, D,  1'b0, 4'b0000, 1'b1, 8'h22, 2'd2},
         '{1'b0, 4'b0101, D,  1'b1, 4'b0001, 1'b1, 8'h00, 2'd0},
         '{1'b0, 4'b0010, DA, 1'b1, 4'b0010, 1'b1, 8'hA5, 2'd1},
         '{1'b0, 4'b0000, DA, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd1},
         '{1'b0, 4'b0000, DA, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd1},
         '{1'b0, 4'b1000, D,  1'b0, 4'b1000, 1'b1, 8'h33, 2'd3},
         '{1'b0, 4'b0001, D,  1'b0, 4'b0000, 1'b1, 8'h33, 2'd3},
         '{1'b1, 4'b0001, D,  1'b0, 4'b0000, 1'b0, 8'h00, 2'd0},
         '{1'b0, 4'b1110, D,  1'b1, 4'b0010, 1'b1, 8'h11, 2'd1}
      };

      rst  = 1'b1;
      rst3 = 1'b1;
      u4.in_valid  = '0;
      u4.in_data   = '0;
      u4.out_ready = 1'b0;
      u3.in_valid  = '0;
      u3.in_data   = '0;
      u3.out_ready = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         rst          = vecs[i].rst;
         u4.in_valid  = vecs[i].valid;
         u4.in_data   = vecs[i].data;
         u4.out_ready = vecs[i].oready;
         #1;
         chk($sformatf("v%0d in_ready", i), 32'(u4.in_ready), 32'(vecs[i].exp_ready));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d out_valid", i), 32'(u4.out_valid), 32'(vecs[i].exp_ovalid));
         chk($sformatf("v%0d out_data", i),  32'(u4.out_data),  32'(vecs[i].exp_odata));
         chk($sformatf("v%0d out_src", i),   32'(u4.out_src),   32'(vecs[i].exp_osrc));
      end

      // N=3: reset with all valid, then rotation must wrap at 3, never reaching 3.
      @(negedge clk);
      rst3         = 1'b1;
      u3.in_valid  = 3'b111;
      u3.in_data   = 24'hCCBBAA;
      u3.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("n3 reset in_ready", 32'(u3.in_ready), 32'd0);
      chk("n3 reset out_valid", 32'(u3.out_valid), 32'd0);
      @(negedge clk);
      rst3 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         logic [7:0] exp_d;
         exp_d = (k % 3 == 0) ? 8'hAA : (k % 3 == 1) ? 8'hBB : 8'hCC;
         #1;
         chk($sformatf("n3 c%0d in_ready", k), 32'(u3.in_ready), 32'(1) << (k % 3));
         @(posedge clk);
         #1;
         chk($sformatf("n3 c%0d out_valid", k), 32'(u3.out_valid), 32'd1);
         chk($sformatf("n3 c%0d out_src", k),   32'(u3.out_src),   32'(k % 3));
         chk($sformatf("n3 c%0d out_data", k),  32'(u3.out_data),  32'(exp_d));
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
